uart_tx_ctrl: RTL

//   Transmit sequencer for the UART core: pops bytes from the TX FIFO fed by the TBR

---
 rtl/uart_tx_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frames TX FIFO bytes per LCR and shifts them out on txd.
// Define UART_TX_BREAK_EN to honour the lcr[5] break control.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  tx_en,
    input  logic [7:0]            lcr,
    input  logic                  tick_os,
    input  logic                  tx_fifo_empty,
    input  logic [DATA_WIDTH-1:0] tx_fifo_rdata,
    output logic                  tx_fifo_rd,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK, S_HOLD
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] sh, sh_n;
    logic [2:0]            bitcnt, bitcnt_n;
    logic                  stop_cnt, stop_cnt_n;
    logic [1:0]            wlen, wlen_n;
    logic                  stop2, stop2_n;
    logic                  par_en, par_en_n;
    logic                  par_bit, par_bit_n;
    logic                  txd_n, rd_n, done_n;
    logic                  brk, bit_end, pop;

`ifdef UART_TX_BREAK_EN
    logic unused_lcr;
    assign brk        = lcr[5];
    assign unused_lcr = ^lcr[7:6];
`else
    logic unused_lcr;
    assign brk        = 1'b0;
    assign unused_lcr = ^lcr[7:5];
`endif

    // Parity over the active data bits only; odd parity starts from 1.
    function automatic logic parity_of(
        input logic [DATA_WIDTH-1:0] d,
        input logic [1:0]            wl,
        input logic                  even
    );
        logic p;
        p = ~even;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (i < 5 + int'(wl)) p ^= d[i];
        return p;
    endfunction

    assign bit_end = tick_os && (cnt == CNT_MAX);
    assign tx_busy = state inside {S_START, S_DATA, S_PAR, S_STOP};

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        sh_n       = sh;
        bitcnt_n   = bitcnt;
        stop_cnt_n = stop_cnt;
        wlen_n     = wlen;
        stop2_n    = stop2;
        par_en_n   = par_en;
        par_bit_n  = par_bit;
        txd_n      = txd;
        rd_n       = 1'b0;
        done_n     = 1'b0;
        pop        = 1'b0;

        if (state != S_IDLE && state != S_BRK && tick_os)
            cnt_n = bit_end ? '0 : cnt + 1'b1;

        unique case (state)
            S_IDLE: begin
                if (brk) begin
                    state_n = S_BRK;
                    txd_n   = 1'b0;
                end else if (tx_en && !tx_fifo_empty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n  = S_DATA;
                    txd_n    = sh[0];
                    bitcnt_n = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bitcnt == 3'd4 + {1'b0, wlen}) begin
                        state_n    = par_en ? S_PAR : S_STOP;
                        txd_n      = par_en ? par_bit : 1'b1;
                        stop_cnt_n = 1'b0;
                    end else begin
                        sh_n     = sh >> 1;
                        txd_n    = sh[1];
                        bitcnt_n = bitcnt + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_n    = S_STOP;
                    txd_n      = 1'b1;
                    stop_cnt_n = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2 && !stop_cnt) begin
                        stop_cnt_n = 1'b1;
                    end else begin
                        done_n = 1'b1;
                        if (brk) begin
                            state_n = S_BRK;
                            txd_n   = 1'b0;
                        end else if (tx_en && !tx_fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            txd_n   = 1'b1;
                        end
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BRK: begin
                if (!brk) begin
                    state_n = S_HOLD;
                    txd_n   = 1'b1;
                    cnt_n   = '0;
                end
            end
            // One full idle bit after break before the next frame may start.
            S_HOLD: begin
                if (brk) begin
                    state_n = S_BRK;
                    txd_n   = 1'b0;
                end else if (bit_end) begin
                    state_n = S_IDLE;
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
                txd_n   = 1'b1;
            end
        endcase

        if (pop) begin
            rd_n       = 1'b1;
            state_n    = S_START;
            sh_n       = tx_fifo_rdata;
            wlen_n     = lcr[1:0];
            stop2_n    = lcr[2];
            par_en_n   = lcr[3];
            par_bit_n  = parity_of(tx_fifo_rdata, lcr[1:0], lcr[4]);
            cnt_n      = '0;
            bitcnt_n   = '0;
            stop_cnt_n = 1'b0;
            txd_n      = 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sh         <= '0;
            bitcnt     <= '0;
            stop_cnt   <= 1'b0;
            wlen       <= '0;
            stop2      <= 1'b0;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            txd        <= 1'b1;
            tx_fifo_rd <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            bitcnt     <= bitcnt_n;
            stop_cnt   <= stop_cnt_n;
            wlen       <= wlen_n;
            stop2      <= stop2_n;
            par_en     <= par_en_n;
            par_bit    <= par_bit_n;
            txd        <= txd_n;
            tx_fifo_rd <= rd_n;
            tx_done    <= done_n;
        end
    end
endmodule
